// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched PC/instruction, flags fetch AdEL,
// and handles stall, flush and exception-request bubbles. AdEL detection is built when IF_ID_ADEL_CHECK_EN is defined.
module if_id_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] F_PC,
  input  logic [31:0] F_Instr,
  input  logic        F_BD,
  input  logic        En_IF_ID,
  input  logic        Flush,
  input  logic        Req,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD,
  output logic        D_Valid
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] load_instr;
  logic [4:0]  load_exc;

`ifdef IF_ID_ADEL_CHECK_EN
  logic fetch_fault;

  // Unsigned window compare plus word alignment.
  assign fetch_fault = (F_PC[1:0] != 2'b00) || (F_PC < TEXT_LO) || (F_PC > TEXT_HI);
  assign load_instr  = fetch_fault ? 32'h0 : F_Instr;
  assign load_exc    = fetch_fault ? EXC_ADEL : EXC_NONE;
`else
  logic unused_text_window;

  assign unused_text_window = ^{TEXT_LO, TEXT_HI};
  assign load_instr         = F_Instr;
  assign load_exc           = EXC_NONE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      D_PC      <= RESET_PC;
      D_Instr   <= 32'h0;
      D_ExcCode <= EXC_NONE;
      D_BD      <= 1'b0;
      D_Valid   <= 1'b0;
    end else if (Req) begin
      D_PC      <= HANDLER_PC;
      D_Instr   <= 32'h0;
      D_ExcCode <= EXC_NONE;
      D_BD      <= 1'b0;
      D_Valid   <= 1'b0;
    end else if (!En_IF_ID) begin
      // Stall holds everything, including a pending flush.
      D_PC      <= D_PC;
      D_Instr   <= D_Instr;
      D_ExcCode <= D_ExcCode;
      D_BD      <= D_BD;
      D_Valid   <= D_Valid;
    end else if (Flush) begin
      // Bubble keeps the real PC so EPC logic never sees zero.
      D_PC      <= F_PC;
      D_Instr   <= 32'h0;
      D_ExcCode <= EXC_NONE;
      D_BD      <= 1'b0;
      D_Valid   <= 1'b0;
    end else begin
      D_PC      <= F_PC;
      D_Instr   <= load_instr;
      D_ExcCode <= load_exc;
      D_BD      <= F_BD;
      D_Valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg; expectations follow IF_ID_ADEL_CHECK_EN.
module tb_if_id_reg;

`ifdef IF_ID_ADEL_CHECK_EN
  localparam bit ADEL_ON = 1'b1;
`else
  localparam bit ADEL_ON = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] F_PC;
  logic [31:0] F_Instr;
  logic        F_BD;
  logic        En_IF_ID;
  logic        Flush;
  logic        Req;
  logic [31:0] D_PC;
  logic [31:0] D_Instr;
  logic [4:0]  D_ExcCode;
  logic        D_BD;
  logic        D_Valid;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  if_id_reg dut (
    .clk       (clk),
    .reset     (reset),
    .F_PC      (F_PC),
    .F_Instr   (F_Instr),
    .F_BD      (F_BD),
    .En_IF_ID  (En_IF_ID),
    .Flush     (Flush),
    .Req       (Req),
    .D_PC      (D_PC),
    .D_Instr   (D_Instr),
    .D_ExcCode (D_ExcCode),
    .D_BD      (D_BD),
    .D_Valid   (D_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bundle order: {D_PC, D_Instr, D_ExcCode, D_BD, D_Valid}
  logic [70:0] obs, exp;
  assign obs = {D_PC, D_Instr, D_ExcCode, D_BD, D_Valid};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic bd,
                       input logic en, input logic fl, input logic rq);
    F_PC = pc; F_Instr = instr; F_BD = bd; En_IF_ID = en; Flush = fl; Req = rq;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(32'h0000_5000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    exp = {32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0};
    chk_cnt++;
    if (obs !== exp) $display("FAIL reset: got %h want %h", obs, exp); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_normal_load();
    drive(32'h0000_3000, 32'h3C01_1234, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    exp = {32'h0000_3000, 32'h3C01_1234, 5'd0, 1'b0, 1'b1};
    chk_cnt++;
    if (obs !== exp) $display("FAIL normal_load: got %h want %h", obs, exp); else pass_cnt++;
    drive(32'h0000_3004, 32'h3421_5678, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    exp = {32'h0000_3004, 32'h3421_5678, 5'd0, 1'b1, 1'b1};
    chk_cnt++;
    if (obs !== exp) $display("FAIL normal_load_bd: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_stall();
    logic [70:0] held;
    held = {32'h0000_3004, 32'h3421_5678, 5'd0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_3100 + 32'(i * 4), 32'hAAAA_0000 + 32'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_cnt++;
      if (obs !== held) $display("FAIL stall_hold_%0d: got %h want %h", i, obs, held); else pass_cnt++;
    end
    drive(32'h0000_3008, 32'h8C22_0004, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    exp = {32'h0000_3008, 32'h8C22_0004, 5'd0, 1'b0, 1'b1};
    chk_cnt++;
    if (obs !== exp) $display("FAIL stall_release: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_fault();
    logic [31:0] pcs [4];
    logic        bad [4];
    pcs = '{32'h0000_3002, 32'h0000_7000, 32'h0000_2FFC, 32'h0000_6FFC};
    bad = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(pcs[i], 32'h1234_5600 + 32'(i), 1'(i & 1), 1'b1, 1'b0, 1'b0);
      tick();
      if (ADEL_ON && bad[i])
        exp = {pcs[i], 32'h0, 5'd4, 1'(i & 1), 1'b1};
      else
        exp = {pcs[i], 32'h1234_5600 + 32'(i), 5'd0, 1'(i & 1), 1'b1};
      chk_cnt++;
      if (obs !== exp) $display("FAIL fault_pc_%h: got %h want %h", pcs[i], obs, exp); else pass_cnt++;
    end
  endtask

  task automatic test_req();
    drive(32'h0000_3050, 32'h2402_000A, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    exp = {32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0};
    chk_cnt++;
    if (obs !== exp) $display("FAIL req_over_stall: got %h want %h", obs, exp); else pass_cnt++;
    drive(32'h0000_4180, 32'h401A_6800, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    exp = {32'h0000_4180, 32'h401A_6800, 5'd0, 1'b0, 1'b1};
    chk_cnt++;
    if (obs !== exp) $display("FAIL req_handler_load: got %h want %h", obs, exp); else pass_cnt++;
    drive(32'h0000_3060, 32'h0000_000C, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    exp = {32'h0000_4180, 32'h0, 5'd0, 1'b0, 1'b0};
    chk_cnt++;
    if (obs !== exp) $display("FAIL req_with_flush: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(32'h0000_3010, 32'h2408_0001, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    exp = {32'h0000_3010, 32'h0, 5'd0, 1'b0, 1'b0};
    chk_cnt++;
    if (obs !== exp) $display("FAIL flush_bubble: got %h want %h", obs, exp); else pass_cnt++;
    drive(32'h0000_3020, 32'h2409_0002, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk_cnt++;
    if (obs !== exp) $display("FAIL flush_stalled_hold: got %h want %h", obs, exp); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      drive(32'h0000_3014 + 32'(i * 4), 32'h1111_0000 + 32'(i), 1'b1, 1'b1, 1'b1, 1'b0);
      tick();
      exp = {32'h0000_3014 + 32'(i * 4), 32'h0, 5'd0, 1'b0, 1'b0};
      chk_cnt++;
      if (obs !== exp) $display("FAIL b2b_flush_%0d: got %h want %h", i, obs, exp); else pass_cnt++;
    end
  endtask

  task automatic test_reset_in_stall();
    drive(32'h0000_3040, 32'h0320_F809, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    exp = {32'h0000_3040, 32'h0320_F809, 5'd0, 1'b0, 1'b1};
    chk_cnt++;
    if (obs !== exp) $display("FAIL pre_reset_load: got %h want %h", obs, exp); else pass_cnt++;
    reset = 1'b1;
    drive(32'h0000_3044, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    exp = {32'h0000_3000, 32'h0, 5'd0, 1'b0, 1'b0};
    chk_cnt++;
    if (obs !== exp) $display("FAIL reset_in_stall: got %h want %h", obs, exp); else pass_cnt++;
    reset = 1'b0;
    drive(32'h0000_3048, 32'h2000_0001, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drive(32'h0000_304C, 32'h2000_0002, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    chk_cnt++;
    if (obs !== exp) $display("FAIL reset_over_req: got %h want %h", obs, exp); else pass_cnt++;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    test_reset();
    test_normal_load();
    test_stall();
    test_fault();
    test_req();
    test_flush();
    test_back_to_back();
    test_reset_in_stall();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
